// File: rtl/onehot_encode_stage.sv
// One-hot to binary encoder stage with a 2-entry in-order output buffer.
// Ports: clk, rst (sync, active-high); d/in_valid/in_ready input handshake;
// idx/err/out_valid/out_ready output handshake; err_cnt_clr/err_cnt counter.
// Macro ONEHOT_ERR_CNT_EN enables the error counter; otherwise err_cnt = 0.
module onehot_encode_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [3:0]  idx,
  output logic        err,
  output logic        out_valid,
  input  logic        out_ready,
  input  logic        err_cnt_clr,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [3:0] enc_idx;
  logic       enc_err;
  logic       accept;
  logic       xfer;
  logic       hd_load;
  logic       hd_sel_in;
  logic       tl_load;

  logic [3:0] hd_idx_q, tl_idx_q;
  logic       hd_err_q, tl_err_q;

  // Downward scan so the lowest set bit wins for multi-hot words.
  always_comb begin
    enc_idx = 4'd0;
    for (int k = 15; k >= 0; k--) begin
      if (d[k]) enc_idx = 4'(k);
    end
    enc_err = (d == 16'd0) ||
              ((d & (d - 16'd1)) != 16'd0);
  end

  // Handshake outputs come from state only.
  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign xfer      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    hd_load   = 1'b0;
    hd_sel_in = 1'b0;
    tl_load   = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          hd_load   = 1'b1;
          hd_sel_in = 1'b1;
        end
      end
      ONE: begin
        if (accept && xfer) begin
          hd_load   = 1'b1;
          hd_sel_in = 1'b1;
        end else if (accept) begin
          state_d = TWO;
          tl_load = 1'b1;
        end else if (xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (xfer) begin
          state_d = ONE;
          hd_load = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hd_idx_q <= 4'd0;
      hd_err_q <= 1'b0;
      tl_idx_q <= 4'd0;
      tl_err_q <= 1'b0;
    end else begin
      if (hd_load) begin
        hd_idx_q <= hd_sel_in ? enc_idx : tl_idx_q;
        hd_err_q <= hd_sel_in ? enc_err : tl_err_q;
      end
      if (tl_load) begin
        tl_idx_q <= enc_idx;
        tl_err_q <= enc_err;
      end
    end
  end

  assign idx = hd_idx_q;
  assign err = hd_err_q;

`ifdef ONEHOT_ERR_CNT_EN
  logic [7:0] cnt_q;

  // A clear coinciding with an accept still counts that word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (err_cnt_clr) begin
      cnt_q <= {7'd0, accept & enc_err};
    end else if (accept && enc_err &&
                 cnt_q != 8'hFF) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign err_cnt = cnt_q;
`else
  logic unused_clr;
  assign unused_clr = err_cnt_clr;
  assign err_cnt    = 8'h00;
`endif

endmodule
